// File: rtl/router_pkg.sv
// Shared types and header helpers for the 1x3 router controller.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE,
        WAIT_EMPTY,
        LOAD_FIRST,
        LOAD_DATA,
        FULL,
        LOAD_AFTER_FULL,
        CHECK,
        DROP
    } state_t;

    localparam logic [1:0] INVALID_ADDR = 2'b11;
    localparam int TIMEOUT_DEF = 30;

    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    function automatic logic [5:0] hdr_len(input logic [7:0] h);
        return h[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

    function automatic logic [1:0] hdr_addr(input logic [7:0] h);
        return h[HDR_ADDR_MSB:HDR_ADDR_LSB];
    endfunction

endpackage

// File: rtl/router_softrst_timer.sv
// Idle-timeout counter for one output FIFO; pulses when unread too long.
module router_softrst_timer #(
    parameter int TIMEOUT = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;
    logic          hit;

    // Pulse lands in the TIMEOUT-th consecutive unread valid cycle.
    assign hit = vld && !rd && (cnt == CW'(TIMEOUT - 1));
    assign soft_reset = hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!vld || rd || hit) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/router_ctrl.sv
// Packet sequencer for the 1x3 router: header decode, FIFO writes,
// stall on occupied/full target, parity/length check, idle soft resets.
module router_ctrl
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [2:0]            fifo_full,
    input  logic [2:0]            fifo_empty,
    input  logic [2:0]            read_enb,
    output logic                  busy,
    output logic [2:0]            write_enb,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  lfd_state,
    output logic [2:0]            vld_out,
    output logic [2:0]            soft_reset,
    output logic                  err
);

    state_t                state;
    logic [1:0]            tgt;
    logic [DATA_WIDTH-1:0] hdr;
    logic [DATA_WIDTH-1:0] par;
    logic [DATA_WIDTH-1:0] rx_par;
    logic [DATA_WIDTH-1:0] hold;
    logic                  hold_par;
    logic [5:0]            cnt;

    logic [3:0] full4;
    logic [3:0] empty4;
    logic [3:0] srst4;
    logic       tgt_full;
    logic       tgt_srst;
    logic       abort;
    logic       we;
    logic [1:0] in_addr;

    assign vld_out = ~fifo_empty;

    for (genvar i = 0; i < 3; i++) begin : g_tmr
        router_softrst_timer #(
            .TIMEOUT(TIMEOUT)
        ) u_tmr (
            .clk       (clk),
            .reset     (reset),
            .vld       (vld_out[i]),
            .rd        (read_enb[i]),
            .soft_reset(soft_reset[i])
        );
    end

    // Padded views so the invalid address never indexes out of range.
    assign full4    = {1'b0, fifo_full};
    assign empty4   = {1'b0, fifo_empty};
    assign srst4    = {1'b0, soft_reset};
    assign tgt_full = full4[tgt];
    assign tgt_srst = srst4[tgt];
    assign in_addr  = hdr_addr(data_in);

    assign abort = tgt_srst && (state != DECODE) && (state != DROP);

    assign busy = state inside {WAIT_EMPTY, LOAD_FIRST, FULL,
                                LOAD_AFTER_FULL, CHECK};

    assign err = (state == CHECK) && !tgt_srst &&
                 ((rx_par != par) || (cnt != hdr_len(hdr)));

    always_comb begin
        we        = 1'b0;
        fifo_din  = '0;
        lfd_state = 1'b0;
        if (!abort && !tgt_full) begin
            unique case (state)
                LOAD_FIRST: begin
                    we        = 1'b1;
                    fifo_din  = hdr;
                    lfd_state = 1'b1;
                end
                LOAD_DATA: begin
                    we       = 1'b1;
                    fifo_din = data_in;
                end
                LOAD_AFTER_FULL: begin
                    we       = 1'b1;
                    fifo_din = hold;
                end
                default: ;
            endcase
        end
    end

    assign write_enb = we ? (3'b001 << tgt) : 3'b000;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= DECODE;
            tgt      <= '0;
            hdr      <= '0;
            par      <= '0;
            rx_par   <= '0;
            hold     <= '0;
            hold_par <= 1'b0;
            cnt      <= '0;
        end else if (abort) begin
            state <= pkt_valid ? DROP : DECODE;
        end else begin
            unique case (state)
                DECODE: begin
                    if (pkt_valid) begin
                        hdr      <= data_in;
                        par      <= data_in;
                        cnt      <= '0;
                        hold_par <= 1'b0;
                        tgt      <= in_addr;
                        if (in_addr == INVALID_ADDR) begin
                            state <= DROP;
                        end else if (empty4[in_addr]) begin
                            state <= LOAD_FIRST;
                        end else begin
                            state <= WAIT_EMPTY;
                        end
                    end
                end
                WAIT_EMPTY: begin
                    if (empty4[tgt]) state <= LOAD_FIRST;
                end
                LOAD_FIRST: begin
                    if (!tgt_full) state <= LOAD_DATA;
                end
                LOAD_DATA: begin
                    if (tgt_full) begin
                        hold     <= data_in;
                        hold_par <= !pkt_valid;
                        state    <= FULL;
                    end else if (pkt_valid) begin
                        par <= par ^ data_in;
                        cnt <= cnt + 1'b1;
                    end else begin
                        rx_par <= data_in;
                        state  <= CHECK;
                    end
                end
                FULL: begin
                    if (!tgt_full) state <= LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (!tgt_full) begin
                        if (hold_par) begin
                            rx_par <= hold;
                            state  <= CHECK;
                        end else begin
                            par   <= par ^ hold;
                            cnt   <= cnt + 1'b1;
                            state <= LOAD_DATA;
                        end
                    end
                end
                CHECK: state <= DECODE;
                DROP: begin
                    if (!pkt_valid) state <= DECODE;
                end
                default: state <= DECODE;
            endcase
        end
    end

endmodule
